// File: rtl/uart_led_pkg.sv
// Shared op codes, parser states and reset values for the UART LED command path.
package uart_led_pkg;

    typedef enum logic [1:0] {
        OP_SET  = 2'b00,
        OP_FADE = 2'b01,
        OP_RATE = 2'b10,
        OP_BAD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ARG,
        ST_GET_SUM,
        ST_EXEC
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] RESET_DUTY   = 8'h40;
    localparam logic [7:0] RESET_STEP   = 8'd1;

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: current/target brightness with a saturating linear fade.
module led_fade_ch
    import uart_led_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] step,
    input  logic       set_en,
    input  logic       fade_en,
    input  logic [7:0] arg,
    output logic [7:0] current,
    output logic       busy
);

    logic [7:0] target;
    logic [7:0] stepped;
    logic [8:0] up;
    logic [8:0] dn;

    assign busy = (current != target);
    assign up   = {1'b0, current} + {1'b0, step};
    assign dn   = {1'b0, current} - {1'b0, step};

    // 9-bit arithmetic so a large step clamps at target instead of wrapping
    always_comb begin
        stepped = target;
        if (current < target) begin
            if (up < {1'b0, target}) stepped = up[7:0];
        end else begin
            if (!dn[8] && dn[7:0] > target) stepped = dn[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current <= RESET_DUTY;
            target  <= RESET_DUTY;
        end else if (set_en) begin
            current <= arg;
            target  <= arg;
        end else if (fade_en) begin
            target  <= arg;
        end else if (tick && busy) begin
            current <= stepped;
        end
    end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Frame parser, fade tick divider and byte timeout feeding NUM_CH fade channels.
module uart_led_cmd_ctrl
    import uart_led_pkg::*;
#(
    parameter int         NUM_CH      = 3,
    parameter int         CLK_FREQ    = 12_000_000,
    parameter int         STEP_HZ     = 1000,
    parameter int         TIMEOUT_CYC = 12000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_CH*8-1:0] duty,
    output logic                busy,
    output logic                ack,
    output logic                frame_err
);

    localparam int TICK_DIV = CLK_FREQ / STEP_HZ;
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int OW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] NCH = 3'(NUM_CH);

    state_e state, state_nxt;
    logic [7:0] cmd_q, arg_q, step;
    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] tout_cnt;
    logic tick, tout, bad, err_nxt, exec, in_frame;
    logic [NUM_CH-1:0] busy_ch;
    op_e op;
    logic [1:0] ch;

    assign op       = op_e'(cmd_q[7:6]);
    assign ch       = cmd_q[1:0];
    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign tout     = (tout_cnt == OW'(TIMEOUT_CYC - 1));
    assign exec     = (state == ST_EXEC);
    assign in_frame = state inside {ST_GET_CMD, ST_GET_ARG, ST_GET_SUM};
    assign bad      = (rx_data != (cmd_q ^ arg_q)) || (op == OP_BAD)
                    || ({1'b0, ch} >= NCH);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nxt = ST_GET_CMD;
            end
            ST_GET_CMD, ST_GET_ARG: begin
                if (rx_valid) begin
                    state_nxt = (state == ST_GET_CMD) ? ST_GET_ARG : ST_GET_SUM;
                end else if (tout) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            ST_GET_SUM: begin
                if (rx_valid) begin
                    state_nxt = bad ? ST_IDLE : ST_EXEC;
                    err_nxt   = bad;
                end else if (tout) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            ST_EXEC: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmd_q     <= '0;
            arg_q     <= '0;
            step      <= RESET_STEP;
            ack       <= 1'b0;
            frame_err <= 1'b0;
            tick_cnt  <= '0;
            tout_cnt  <= '0;
        end else begin
            ack       <= exec;
            frame_err <= err_nxt;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            tout_cnt  <= (in_frame && !rx_valid) ? tout_cnt + 1'b1 : '0;
            if (rx_valid && state == ST_GET_CMD) cmd_q <= rx_data;
            if (rx_valid && state == ST_GET_ARG) arg_q <= rx_data;
            // RATE lands at the EXEC edge, so any tick in that cycle uses the old step
            if (exec && op == OP_RATE) step <= (arg_q == 8'd0) ? 8'd1 : arg_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = exec && (ch == 2'(i));
        led_fade_ch u_ch (
            .clk     (CLK),
            .rst_n   (RST_N),
            .tick    (tick),
            .step    (step),
            .set_en  (sel && op == OP_SET),
            .fade_en (sel && op == OP_FADE),
            .arg     (arg_q),
            .current (duty[i*8 +: 8]),
            .busy    (busy_ch[i])
        );
    end

    assign busy = |busy_ch;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Directed bench: framing, SET/FADE/RATE, error frames, timeout and tick collision.
module tb_uart_led_cmd_ctrl;

    localparam int NUM_CH   = 3;
    localparam int CLK_FREQ = 100;
    localparam int STEP_HZ  = 10;
    localparam int TICK_DIV = CLK_FREQ / STEP_HZ;
    localparam int TOUT     = 40;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [23:0] duty;
    logic        busy, ack, frame_err;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int err_cnt = 0;

    uart_led_cmd_ctrl #(
        .NUM_CH      (NUM_CH),
        .CLK_FREQ    (CLK_FREQ),
        .STEP_HZ     (STEP_HZ),
        .TIMEOUT_CYC (TOUT),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .duty      (duty),
        .busy      (busy),
        .ack       (ack),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ack) ack_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 9'd255) ? 8'hFF : s[7:0];
    endfunction

    task automatic drive_at(input logic [7:0] b, input int n);
        repeat (n) @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_at(b, 1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic err_frame(input string tag, input logic [7:0] c,
                             input logic [7:0] a, input logic [7:0] s);
        int a0, e0;
        logic [23:0] d0;
        a0 = ack_cnt;
        e0 = err_cnt;
        d0 = duty;
        send_frame(8'hA5, c, a, s);
        check({tag, "_err"}, err_cnt - e0, 1);
        check({tag, "_noack"}, ack_cnt - a0, 0);
        check({tag, "_duty"}, duty, d0);
    endtask

    initial begin
        int a0, e0, gap, last_chg;
        logic [7:0] prev, cur, v;
        bit first, done;

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_duty", duty, 24'h404040);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_err", frame_err, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // SET ch1 with exact latency
        a0 = ack_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hC0);
        drive_at(8'hC1, 1);
        check("set_ack_early", ack, 0);
        @(negedge CLK);
        check("set_ack", ack, 1);
        check("set_duty", duty, 24'h40C040);
        check("set_busy", busy, 0);
        @(negedge CLK);
        check("set_ack_pulse", ack, 0);

        // reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h00);
        RST_N = 1'b0;
        @(negedge CLK);
        check("mid_rst_duty", duty, 24'h404040);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_err", frame_err, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        a0 = ack_cnt;
        send_frame(8'hA5, 8'h00, 8'h80, 8'h80);
        check("post_rst_ack", ack_cnt - a0, 1);
        check("post_rst_duty", duty, 24'h404080);

        // rejected frames
        err_frame("csum", 8'h00, 8'h10, 8'h11);
        err_frame("op11", 8'hC0, 8'h00, 8'hC0);
        err_frame("ch3", 8'h03, 8'h10, 8'h13);

        // noise ahead of a frame is ignored silently
        e0 = err_cnt;
        a0 = ack_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'hA5, 8'h01, 8'h20, 8'h21);
        check("noise_err", err_cnt - e0, 0);
        check("noise_ack", ack_cnt - a0, 1);
        check("noise_duty", duty, 24'h402080);

        // inter-byte timeout
        e0 = err_cnt;
        a0 = ack_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TOUT + 5) @(negedge CLK);
        check("tout_err", err_cnt - e0, 1);
        check("tout_noack", ack_cnt - a0, 0);
        send_frame(8'hA5, 8'h01, 8'h30, 8'h31);
        check("tout_next_ack", ack_cnt - a0, 1);
        check("tout_next_duty", duty, 24'h403080);

        // RATE 10, then FADE ch2 to FF
        a0 = ack_cnt;
        send_frame(8'hA5, 8'h80, 8'h0A, 8'h8A);
        check("rate_ack", ack_cnt - a0, 1);
        check("rate_duty", duty, 24'h403080);
        send_byte(8'hA5);
        send_byte(8'h42);
        send_byte(8'hFF);
        drive_at(8'hBD, 1);
        @(negedge CLK);
        check("fade_start", duty[23:16], 8'h40);
        check("fade_busy", busy, 1);
        prev = 8'h40;
        first = 1'b1;
        done = 1'b0;
        last_chg = 0;
        for (int c = 1; c <= 400 && !done; c++) begin
            @(negedge CLK);
            cur = duty[23:16];
            if (cur != prev) begin
                check("fade_val", cur, sat_add(prev, 8'd10));
                if (!first) check("fade_gap", c - last_chg, TICK_DIV);
                check("fade_busy_step", busy, (cur != 8'hFF));
                first = 1'b0;
                last_chg = c;
                prev = cur;
                if (cur == 8'hFF) done = 1'b1;
            end
        end
        check("fade_done", prev, 8'hFF);
        check("fade_others", duty[15:0], 16'h3080);

        // SET on ch0 landing on a tick while ch0 and ch1 fade
        send_frame(8'hA5, 8'h40, 8'h00, 8'h40);
        send_frame(8'hA5, 8'h41, 8'hFF, 8'hBE);
        v = duty[15:8];
        done = 1'b0;
        for (int c = 0; c < 3 * TICK_DIV && !done; c++) begin
            @(negedge CLK);
            if (duty[15:8] != v) done = 1'b1;
        end
        check("coll_sync", done, 1);
        v = duty[15:8];
        a0 = ack_cnt;
        drive_at(8'hA5, 1);
        drive_at(8'h00, 1);
        drive_at(8'h55, 1);
        drive_at(8'h55, 2);
        @(negedge CLK);
        check("coll_ack", ack, 1);
        check("coll_ch0", duty[7:0], 8'h55);
        check("coll_ch1", duty[15:8], sat_add(v, 8'd10));
        repeat (3 * TICK_DIV) @(negedge CLK);
        check("coll_ch0_hold", duty[7:0], 8'h55);
        check("coll_ch1_more", duty[15:8], sat_add(v, 8'd40));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
